// File: rtl/ifu_pkg.sv
// Shared widths, opcodes, NOP encoding and FSM state type for the fetch unit.
// Also holds the B/J immediate decode helpers used by the static predictor.
package ifu_pkg;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [6:0]             OPC_BXX   = 7'b1100011;
    localparam logic [6:0]             OPC_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } ifu_state_e;

    function automatic logic [PC_WIDTH-1:0] imm_b(input logic [INSTR_WIDTH-1:0] instr);
        return {{(PC_WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [PC_WIDTH-1:0] imm_j(input logic [INSTR_WIDTH-1:0] instr);
        return {{(PC_WIDTH-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch unit bus bundle: instruction memory, EX redirect and the decode handshake.
// The master side is the fetch unit; the slave side is memory/EX/decode.
interface ifu_if;
    import ifu_pkg::*;

    logic                   imem_req_o;
    logic [PC_WIDTH-1:0]    imem_addr_o;
    logic                   imem_gnt_i;
    logic                   imem_rvalid_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    logic                   ex_pipe_flush_i;
    logic [PC_WIDTH-1:0]    ex_pipe_flush_pc_i;
    logic                   if_valid_o;
    logic                   id_ready_i;
    logic [PC_WIDTH-1:0]    if_pc_o;
    logic [INSTR_WIDTH-1:0] if_instr_o;
    logic                   if_prdt_taken_o;

    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, if_prdt_taken_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ex_pipe_flush_i, ex_pipe_flush_pc_i,
               id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, if_prdt_taken_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ex_pipe_flush_i, ex_pipe_flush_pc_i,
               id_ready_i
    );

endinterface

// File: rtl/ifu_bpu.sv
// Combinational static predictor: backward branches and JAL predicted taken.
// Produces the predicted next fetch PC for the instruction at pc.
module ifu_bpu
    import ifu_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   prdt_taken,
    output logic [PC_WIDTH-1:0]    prdt_pc
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];

    always_comb begin
        prdt_taken = 1'b0;
        prdt_pc    = pc + PC_WIDTH'(4);
        case (opcode)
            OPC_BXX: begin
                if (instr[31]) begin
                    prdt_taken = 1'b1;
                    prdt_pc    = pc + imm_b(instr);
                end
            end
            OPC_JAL: begin
                prdt_taken = 1'b1;
                prdt_pc    = pc + imm_j(instr);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM, fetch PC and the
// valid/ready output register towards decode.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic  clk,
    input  logic  rst,
    ifu_if.master bus
);

    ifu_state_e             state;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   if_valid;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic                   if_taken;

    logic                   slot_free;
    logic                   req;
    logic                   gnt_acc;
    logic                   rsp_acc;
    logic                   flush;
    logic                   prdt_taken;
    logic [PC_WIDTH-1:0]    prdt_pc;

    assign flush     = bus.ex_pipe_flush_i;
    assign slot_free = ~if_valid | bus.id_ready_i;
    assign req       = (state == StReq) & slot_free;
    assign gnt_acc   = req & bus.imem_gnt_i;
    // A response landing together with a flush belongs to the wrong path.
    assign rsp_acc   = (state == StWait) & bus.imem_rvalid_i & ~flush;

    ifu_bpu u_bpu (
        .instr      (bus.imem_rdata_i),
        .pc         (fetch_pc),
        .prdt_taken (prdt_taken),
        .prdt_pc    (prdt_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            fetch_pc <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= INSTR_NOP;
            if_taken <= 1'b0;
        end else begin
            case (state)
                StIdle:  state <= StReq;
                StReq: begin
                    if (gnt_acc) begin
                        state <= flush ? StDrain : StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid_i) begin
                        state <= StReq;
                    end else if (flush) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (bus.imem_rvalid_i) begin
                        state <= StReq;
                    end
                end
                default: state <= StIdle;
            endcase

            if (flush) begin
                fetch_pc <= bus.ex_pipe_flush_pc_i;
            end else if (rsp_acc) begin
                fetch_pc <= prdt_pc;
            end

            if (flush) begin
                if_valid <= 1'b0;
            end else if (rsp_acc) begin
                if_valid <= 1'b1;
                if_pc    <= fetch_pc;
                if_instr <= bus.imem_rdata_i;
                if_taken <= prdt_taken;
            end else if (bus.id_ready_i) begin
                if_valid <= 1'b0;
            end
        end
    end

    assign bus.imem_req_o      = req;
    assign bus.imem_addr_o     = fetch_pc;
    assign bus.if_valid_o      = if_valid;
    assign bus.if_pc_o         = if_pc;
    assign bus.if_instr_o      = if_instr;
    assign bus.if_prdt_taken_o = if_taken;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed predictor vectors, flush/stall/reset sequences, then a
// randomized memory/decode/flush run checked against an instruction-stream model.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] next;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    vec_t        vecs[8];
    logic [31:0] mem_instr[64];
    logic [31:0] mem_step[64];
    logic        mem_taken[64];

    ifu_if bus ();

    ifu #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.imem_gnt_i      = 1'b0;
        bus.imem_rvalid_i   = 1'b0;
        bus.ex_pipe_flush_i = 1'b0;
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req_o) break;
            step();
        end
        check("req_timeout", 32'(bus.imem_req_o), 32'd1);
    endtask

    // Zero-wait memory: grant in the request cycle, respond in the next one.
    task automatic serve(input logic [31:0] instr, input logic [31:0] exp_addr);
        wait_req();
        check("req_addr", bus.imem_addr_o, exp_addr);
        bus.imem_gnt_i = 1'b1;
        step();
        check("wait_no_req", 32'(bus.imem_req_o), 32'd0);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = instr;
        step();
        check("rsp_valid", 32'(bus.if_valid_o), 32'd1);
        check("rsp_pc", bus.if_pc_o, exp_addr);
        check("rsp_instr", bus.if_instr_o, instr);
    endtask

    task automatic flush_to(input logic [31:0] pc);
        bus.ex_pipe_flush_i    = 1'b1;
        bus.ex_pipe_flush_pc_i = pc;
        step();
        check("flush_clears_valid", 32'(bus.if_valid_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req_o), 32'd0);
        check({tag, "_addr"}, bus.imem_addr_o, RST_PC);
        check({tag, "_valid"}, 32'(bus.if_valid_o), 32'd0);
        check({tag, "_pc"}, bus.if_pc_o, 32'd0);
        check({tag, "_instr"}, bus.if_instr_o, 32'h0000_0013);
        check({tag, "_taken"}, 32'(bus.if_prdt_taken_o), 32'd0);
    endtask

    function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'h6f};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] exp_pc;
        logic [31:0] paddr;
        logic [2:0]  f3;
        logic [5:0]  idx;
        int          off;
        int          r;
        int          pend;
        int          cnt;
        int          hs;

        vecs[0] = '{32'h0000_0100, enc_b(-16, 3'd0), 1'b1, 32'h0000_00F0};
        vecs[1] = '{32'h0000_0100, enc_b(32, 3'd1), 1'b0, 32'h0000_0104};
        vecs[2] = '{32'h0000_0200, enc_j(64), 1'b1, 32'h0000_0240};
        vecs[3] = '{32'h0000_0300, {12'h010, 5'd1, 3'd0, 5'd1, 7'h67}, 1'b0, 32'h0000_0304};
        vecs[4] = '{32'h0000_0000, enc_b(-4096, 3'd4), 1'b1, 32'hFFFF_F000};
        vecs[5] = '{32'hFFFF_FFFC, enc_j(8), 1'b1, 32'h0000_0004};
        vecs[6] = '{32'hFFFF_FFFC, enc_b(8, 3'd5), 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h0000_1000, enc_j(-1048576), 1'b1, 32'hFFF0_1000};

        bus.imem_gnt_i         = 1'b0;
        bus.imem_rvalid_i      = 1'b0;
        bus.imem_rdata_i       = '0;
        bus.ex_pipe_flush_i    = 1'b0;
        bus.ex_pipe_flush_pc_i = '0;
        bus.id_ready_i         = 1'b1;

        // Reset and sequential fetch from RESET_PC.
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("idle_no_req", 32'(bus.imem_req_o), 32'd0);
        step();
        check("first_req", 32'(bus.imem_req_o), 32'd1);
        serve(32'h0010_0093, 32'h0000_0080);
        check("seq_taken0", 32'(bus.if_prdt_taken_o), 32'd0);
        check("b2b_req", 32'(bus.imem_req_o), 32'd1);
        serve(32'h0020_0113, 32'h0000_0084);
        check("seq_taken1", 32'(bus.if_prdt_taken_o), 32'd0);
        serve(32'h0030_0193, 32'h0000_0088);
        check("seq_taken2", 32'(bus.if_prdt_taken_o), 32'd0);

        // Predictor vectors, each fetched from a flush target.
        for (int i = 0; i < 8; i++) begin
            flush_to(vecs[i].pc);
            serve(vecs[i].instr, vecs[i].pc);
            check("vec_taken", 32'(bus.if_prdt_taken_o), 32'(vecs[i].taken));
            check("vec_next_req", 32'(bus.imem_req_o), 32'd1);
            check("vec_next_addr", bus.imem_addr_o, vecs[i].next);
        end

        // Flush in WAIT, response arrives later in DRAIN.
        wait_req();
        bus.imem_gnt_i = 1'b1;
        step();
        bus.ex_pipe_flush_i    = 1'b1;
        bus.ex_pipe_flush_pc_i = 32'h0000_0200;
        step();
        check("drain_valid", 32'(bus.if_valid_o), 32'd0);
        check("drain_no_req", 32'(bus.imem_req_o), 32'd0);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'h00A0_0513;
        step();
        check("drained_valid", 32'(bus.if_valid_o), 32'd0);
        check("drained_req", 32'(bus.imem_req_o), 32'd1);
        check("drained_addr", bus.imem_addr_o, 32'h0000_0200);

        // Flush and rvalid in the same cycle.
        bus.imem_gnt_i = 1'b1;
        step();
        bus.ex_pipe_flush_i    = 1'b1;
        bus.ex_pipe_flush_pc_i = 32'h0000_0300;
        bus.imem_rvalid_i      = 1'b1;
        bus.imem_rdata_i       = 32'h00B0_0593;
        step();
        check("flush_rsp_valid", 32'(bus.if_valid_o), 32'd0);
        check("flush_rsp_req", 32'(bus.imem_req_o), 32'd1);
        check("flush_rsp_addr", bus.imem_addr_o, 32'h0000_0300);

        // Decode stall for five cycles.
        serve(32'h00C0_0613, 32'h0000_0300);
        bus.id_ready_i = 1'b0;
        #1;
        check("stall_no_req", 32'(bus.imem_req_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", 32'(bus.imem_req_o), 32'd0);
            check("stall_valid", 32'(bus.if_valid_o), 32'd1);
            check("stall_pc", bus.if_pc_o, 32'h0000_0300);
            check("stall_instr", bus.if_instr_o, 32'h00C0_0613);
            check("stall_taken", 32'(bus.if_prdt_taken_o), 32'd0);
        end
        bus.id_ready_i = 1'b1;
        #1;
        check("release_req", 32'(bus.imem_req_o), 32'd1);
        check("release_addr", bus.imem_addr_o, 32'h0000_0304);
        step();
        check("release_valid", 32'(bus.if_valid_o), 32'd0);

        // Reset asserted mid-WAIT, late responses ignored.
        wait_req();
        bus.imem_gnt_i = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check_reset_outputs("midwait");
        step();
        rst = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'h0040_006F;
        #1;
        step();
        check("late_valid0", 32'(bus.if_valid_o), 32'd0);
        check("restart_req", 32'(bus.imem_req_o), 32'd1);
        check("restart_addr", bus.imem_addr_o, RST_PC);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'h0040_006F;
        step();
        check("late_valid1", 32'(bus.if_valid_o), 32'd0);
        serve(32'h00D0_0693, RST_PC);

        // Randomized program: the model knows each word's kind and offset.
        for (int i = 0; i < 64; i++) begin
            r   = int'($urandom_range(0, 19));
            off = (int'($urandom_range(0, 31)) - 16) * 4;
            ins = $urandom;
            if (r < 10) begin
                ins[6:0]     = 7'h13;
                mem_taken[i] = 1'b0;
                mem_step[i]  = 32'd4;
            end else if (r < 14) begin
                f3 = 3'($urandom_range(0, 7));
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                ins          = enc_b(off, f3);
                mem_taken[i] = (off < 0);
                mem_step[i]  = (off < 0) ? 32'(off) : 32'd4;
            end else if (r < 17) begin
                ins          = enc_j(off);
                mem_taken[i] = 1'b1;
                mem_step[i]  = 32'(off);
            end else if (r < 18) begin
                ins[6:0]     = 7'h67;
                ins[14:12]   = 3'd0;
                mem_taken[i] = 1'b0;
                mem_step[i]  = 32'd4;
            end else begin
                ins[6:0]     = 7'h37;
                mem_taken[i] = 1'b0;
                mem_step[i]  = 32'd4;
            end
            mem_instr[i] = ins;
        end

        flush_to(32'h0000_0000);
        exp_pc = 32'h0000_0000;
        pend   = 0;
        cnt    = 0;
        hs     = 0;
        paddr  = '0;
        for (int c = 0; c < 4000; c++) begin
            bus.id_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                bus.ex_pipe_flush_i    = 1'b1;
                bus.ex_pipe_flush_pc_i = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (pend != 0) begin
                if (cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mem_instr[paddr[7:2]];
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            #1;
            if (bus.if_valid_o) begin
                idx = exp_pc[7:2];
                check("rnd_pc", bus.if_pc_o, exp_pc);
                check("rnd_instr", bus.if_instr_o, mem_instr[idx]);
                check("rnd_taken", 32'(bus.if_prdt_taken_o), 32'(mem_taken[idx]));
                if (bus.id_ready_i && !bus.ex_pipe_flush_i) begin
                    exp_pc = exp_pc + mem_step[idx];
                    hs++;
                end
            end
            if (bus.imem_req_o) begin
                check("rnd_one_outstanding", 32'(pend), 32'd0);
                check("rnd_req_in_stall", 32'(bus.if_valid_o & ~bus.id_ready_i), 32'd0);
                check("rnd_addr_align", 32'(bus.imem_addr_o[1:0]), 32'd0);
                if ($urandom_range(0, 1) != 0) begin
                    bus.imem_gnt_i = 1'b1;
                    pend  = 1;
                    paddr = bus.imem_addr_o;
                    cnt   = int'($urandom_range(0, 2));
                end
            end
            if (bus.ex_pipe_flush_i) begin
                exp_pc = bus.ex_pipe_flush_pc_i;
            end
            step();
        end
        check("rnd_progress", 32'(hs > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
